// File: rtl/xbar_pkg.sv
// Shared definitions for the XbarV1 crossbar arbiters.
//   - ARB_MODE_FIXED / ARB_MODE_RR : arbitration mode encodings
//   - LOCK_CNT_W                   : width of the lock watchdog counter
//   - arb_state_e                  : per-slave arbiter states
//   - clog2 / sel_width            : index-width helpers (sel_width never returns 0)
package xbar_pkg;

  localparam int unsigned ARB_MODE_FIXED = 0;
  localparam int unsigned ARB_MODE_RR    = 1;
  localparam int unsigned LOCK_CNT_W     = 16;

  typedef enum logic [0:0] {
    StIdle,
    StOwned
  } arb_state_e;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned v;
    res = 0;
    v   = (value > 0) ? value - 1 : 0;
    while (v > 0) begin
      res++;
      v = v >> 1;
    end
    return res;
  endfunction

  // Index width with a floor of 1 so a single-master build still has a mux select bit.
  function automatic int unsigned sel_width(input int unsigned n);
    int unsigned w;
    w = clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/arb_rr_pick.sv
// Combinational winner selection for the slave arbiter.
//   Rotates the request vector so the search starts at `ptr` (round-robin) or at 0 (fixed
//   priority), then takes the first set bit.
// Ports:
//   req   in   NUM_MASTERS  eligible requests
//   ptr   in   SEL_W        round-robin start index (ignored in fixed mode)
//   mode  in   1            1 = round-robin, 0 = fixed priority
//   gnt   out  NUM_MASTERS  one-hot winner (zero when no request)
//   idx   out  SEL_W        winner index (0 when no request)
//   valid out  1            at least one request present
module arb_rr_pick
  import xbar_pkg::*;
#(
  parameter int unsigned NUM_MASTERS = 2,
  parameter int unsigned SEL_W       = sel_width(NUM_MASTERS)
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [SEL_W-1:0]       ptr,
  input  logic                   mode,
  output logic [NUM_MASTERS-1:0] gnt,
  output logic [SEL_W-1:0]       idx,
  output logic                   valid
);

  logic [2*NUM_MASTERS-1:0] req_dbl;
  logic [NUM_MASTERS-1:0]   req_rot;
  int unsigned              start;
  int unsigned              win;

  assign start   = mode ? (32'(ptr) % NUM_MASTERS) : 0;
  // Doubling the vector turns the wrap-around search into a plain right shift.
  assign req_dbl = {req, req};
  assign req_rot = NUM_MASTERS'(req_dbl >> start);

  always_comb begin
    valid = 1'b0;
    win   = 0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (!valid && req_rot[i]) begin
        valid = 1'b1;
        win   = (start + i) % NUM_MASTERS;
      end
    end
  end

  assign gnt = valid ? (NUM_MASTERS'(1) << win) : '0;
  assign idx = SEL_W'(win);

endmodule

// File: rtl/xbar_slave_arbiter_rr.sv
// Per-slave arbiter for the XbarV1 crossbar.
//   Chooses which of NUM_MASTERS masters owns the slave port and drives the slave-side mux
//   select. Fixed-priority or round-robin selection, registered one-hot grant, lock to hold
//   ownership across multi-beat transfers.
// Optional feature (macro ARB_LOCK_TIMEOUT_EN): a watchdog revokes an owner that holds through
//   lock for LOCK_TIMEOUT contended cycles, pulses o_Timeout, and masks the revoked master
//   until it drops its request. Without the macro o_Timeout is tied low.
// Ports:
//   i_Clk      in   1            clock, rising edge
//   i_Rst      in   1            synchronous reset, active high
//   i_Req      in   NUM_MASTERS  per-master request
//   i_Lock     in   NUM_MASTERS  per-master lock, honoured only for the current owner
//   o_Gnt      out  NUM_MASTERS  registered one-hot (or zero) grant
//   o_MuxSel   out  SEL_W        index of current or last owner
//   o_Busy     out  1            any grant asserted
//   o_Timeout  out  1            one-cycle pulse on watchdog revoke
module xbar_slave_arbiter_rr
  import xbar_pkg::*;
#(
  parameter int unsigned  NUM_MASTERS  = 2,
  parameter int unsigned  ARB_MODE     = ARB_MODE_RR,
  parameter int unsigned  LOCK_TIMEOUT = 256,
  localparam int unsigned SEL_W        = sel_width(NUM_MASTERS)
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  input  logic [NUM_MASTERS-1:0] i_Req,
  input  logic [NUM_MASTERS-1:0] i_Lock,
  output logic [NUM_MASTERS-1:0] o_Gnt,
  output logic [SEL_W-1:0]       o_MuxSel,
  output logic                   o_Busy,
  output logic                   o_Timeout
);

  // Elaboration-time parameter range checks.
  if (NUM_MASTERS < 1 || NUM_MASTERS > 16) begin : g_bad_num_masters
    $error("NUM_MASTERS must be in 1..16");
  end
  if (ARB_MODE > ARB_MODE_RR) begin : g_bad_arb_mode
    $error("ARB_MODE must be 0 or 1");
  end
  if (LOCK_TIMEOUT < 2 || LOCK_TIMEOUT > 65535) begin : g_bad_lock_timeout
    $error("LOCK_TIMEOUT must be in 2..65535");
  end

  arb_state_e             state_q, state_d;
  logic [NUM_MASTERS-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic [SEL_W-1:0]       ptr_q, ptr_d;
  logic                   timeout_q, timeout_d;

  logic                   owner_req;
  logic                   owner_lock;
  logic                   lock_hold;
  logic                   contended;
  logic                   hold;
  logic                   revoke;
  logic [NUM_MASTERS-1:0] arb_mask;
  logic [NUM_MASTERS-1:0] eligible;
  logic [NUM_MASTERS-1:0] others;
  logic [NUM_MASTERS-1:0] pick_req;
  logic [NUM_MASTERS-1:0] pick_gnt;
  logic [SEL_W-1:0]       pick_idx;
  logic                   pick_valid;
  logic [SEL_W-1:0]       next_ptr;

  // Owner's request/lock extracted by masking with the one-hot grant (no index decode).
  assign owner_req  = |(i_Req & gnt_q);
  assign owner_lock = |(i_Lock & gnt_q);
  assign eligible   = i_Req & ~arb_mask;
  assign others     = eligible & ~gnt_q;
  assign contended  = |others;
  assign lock_hold  = (state_q == StOwned) && owner_req && owner_lock;

  // An unlocked owner stays in the candidate set: fixed mode then re-picks it when it is
  // still the highest priority, while round-robin naturally ranks it last.
  assign pick_req = revoke ? others : eligible;

  arb_rr_pick #(
    .NUM_MASTERS(NUM_MASTERS),
    .SEL_W      (SEL_W)
  ) u_pick (
    .req  (pick_req),
    .ptr  (ptr_q),
    .mode (ARB_MODE == ARB_MODE_RR),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .valid(pick_valid)
  );

  assign next_ptr = SEL_W'((32'(pick_idx) + 1) % NUM_MASTERS);

`ifdef ARB_LOCK_TIMEOUT_EN
  logic [LOCK_CNT_W-1:0]  wd_cnt_q, wd_cnt_d;
  logic [NUM_MASTERS-1:0] mask_q, mask_d;
  logic                   wd_hit;

  assign wd_hit   = ({1'b0, wd_cnt_q} + (LOCK_CNT_W + 1)'(1)) >= (LOCK_CNT_W + 1)'(LOCK_TIMEOUT);
  assign revoke   = lock_hold && contended && wd_hit;
  assign arb_mask = mask_q;

  always_comb begin
    wd_cnt_d = '0;
    if (lock_hold && contended && !revoke) begin
      wd_cnt_d = wd_cnt_q + LOCK_CNT_W'(1);
    end
    // A revoked master stays masked until it lets go of its request.
    mask_d = mask_q & i_Req;
    if (revoke) begin
      mask_d = mask_d | gnt_q;
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      wd_cnt_q <= '0;
      mask_q   <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      mask_q   <= mask_d;
    end
  end
`else
  assign revoke   = 1'b0;
  assign arb_mask = '0;
`endif

  assign hold = (state_q == StOwned) && owner_req && (owner_lock || !contended) && !revoke;

  // State register.
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q   <= StIdle;
      gnt_q     <= '0;
      sel_q     <= '0;
      ptr_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    timeout_d = revoke;
    if (!hold) begin
      if (pick_valid) begin
        state_d = StOwned;
        gnt_d   = pick_gnt;
        sel_d   = pick_idx;
        // Pointer only advances on a genuinely new owner.
        if (pick_gnt != gnt_q) begin
          ptr_d = next_ptr;
        end
      end else begin
        state_d = StIdle;
        gnt_d   = '0;
      end
    end
  end

  // Outputs: all registered; sel holds the last owner while idle.
  always_comb begin
    o_Gnt     = gnt_q;
    o_MuxSel  = sel_q;
    o_Busy    = (state_q == StOwned);
    o_Timeout = timeout_q;
  end

endmodule

// File: tb/tb_xbar_slave_arbiter_rr.sv
// Directed bench for xbar_slave_arbiter_rr: a 2-master round-robin instance (LOCK_TIMEOUT=8),
// a 4-master round-robin instance and a 4-master fixed-priority instance share clock/reset.
// Watchdog expectations follow ARB_LOCK_TIMEOUT_EN.
module tb_xbar_slave_arbiter_rr;

  logic       clk;
  logic       rst;

  logic [1:0] req2, lock2, gnt2;
  logic [0:0] sel2;
  logic       busy2, to2;

  logic [3:0] req4r, lock4r, gnt4r;
  logic [1:0] sel4r;
  logic       busy4r, to4r;

  logic [3:0] req4f, lock4f, gnt4f;
  logic [1:0] sel4f;
  logic       busy4f, to4f;

  int n_cmp;
  int n_err;

  xbar_slave_arbiter_rr #(
    .NUM_MASTERS (2),
    .ARB_MODE    (1),
    .LOCK_TIMEOUT(8)
  ) u_dut2 (
    .i_Clk    (clk),
    .i_Rst    (rst),
    .i_Req    (req2),
    .i_Lock   (lock2),
    .o_Gnt    (gnt2),
    .o_MuxSel (sel2),
    .o_Busy   (busy2),
    .o_Timeout(to2)
  );

  xbar_slave_arbiter_rr #(
    .NUM_MASTERS (4),
    .ARB_MODE    (1),
    .LOCK_TIMEOUT(256)
  ) u_rr4 (
    .i_Clk    (clk),
    .i_Rst    (rst),
    .i_Req    (req4r),
    .i_Lock   (lock4r),
    .o_Gnt    (gnt4r),
    .o_MuxSel (sel4r),
    .o_Busy   (busy4r),
    .o_Timeout(to4r)
  );

  xbar_slave_arbiter_rr #(
    .NUM_MASTERS (4),
    .ARB_MODE    (0),
    .LOCK_TIMEOUT(256)
  ) u_fx4 (
    .i_Clk    (clk),
    .i_Rst    (rst),
    .i_Req    (req4f),
    .i_Lock   (lock4f),
    .o_Gnt    (gnt4f),
    .o_MuxSel (sel4f),
    .o_Busy   (busy4f),
    .o_Timeout(to4f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    rst    = 1'b1;
    req2   = '0;
    lock2  = '0;
    req4r  = '0;
    lock4r = '0;
    req4f  = '0;
    lock4f = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check_eq("rst_gnt", 32'(gnt2), 32'h0);
    check_eq("rst_sel", 32'(sel2), 32'h0);
    check_eq("rst_busy", 32'(busy2), 32'h0);
    check_eq("rst_timeout", 32'(to2), 32'h0);

    // One-cycle grant latency from idle
    req2 = 2'b01;
    #1;
    check_eq("lat_pre_edge", 32'(gnt2), 32'h0);
    tick();
    check_eq("lat_gnt", 32'(gnt2), 32'h1);
    check_eq("lat_sel", 32'(sel2), 32'h0);
    check_eq("lat_busy", 32'(busy2), 32'h1);
    req2 = 2'b00;
    tick();
    check_eq("idle_gnt", 32'(gnt2), 32'h0);
    check_eq("idle_busy", 32'(busy2), 32'h0);

    // Mux select holds the last owner while idle
    req2 = 2'b10;
    tick();
    check_eq("m1_gnt", 32'(gnt2), 32'h2);
    check_eq("m1_sel", 32'(sel2), 32'h1);
    req2 = 2'b00;
    tick();
    check_eq("sel_hold_gnt", 32'(gnt2), 32'h0);
    check_eq("sel_hold_sel", 32'(sel2), 32'h1);

    // Lock hold: M0 held three contended cycles, then hand-off with no idle bubble
    req2  = 2'b01;
    lock2 = 2'b01;
    tick();
    check_eq("lock_first_gnt", 32'(gnt2), 32'h1);
    req2 = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("lock_hold_gnt", 32'(gnt2), 32'h1);
    end
    req2  = 2'b10;
    lock2 = 2'b00;
    tick();
    check_eq("handoff_gnt", 32'(gnt2), 32'h2);
    check_eq("handoff_busy", 32'(busy2), 32'h1);
    check_eq("handoff_sel", 32'(sel2), 32'h1);
    req2 = 2'b00;
    tick();
    check_eq("after_handoff_gnt", 32'(gnt2), 32'h0);

    // Watchdog: M0 locked while M1 requests for 8 contended edges
    req2  = 2'b01;
    lock2 = 2'b01;
    tick();
    check_eq("wd_own_gnt", 32'(gnt2), 32'h1);
    req2 = 2'b11;
    for (int i = 0; i < 7; i++) begin
      tick();
      check_eq("wd_pre_gnt", 32'(gnt2), 32'h1);
      check_eq("wd_pre_timeout", 32'(to2), 32'h0);
    end
    tick();
`ifdef ARB_LOCK_TIMEOUT_EN
    check_eq("wd_revoke_gnt", 32'(gnt2), 32'h2);
    check_eq("wd_revoke_timeout", 32'(to2), 32'h1);
    check_eq("wd_revoke_sel", 32'(sel2), 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("wd_masked_gnt", 32'(gnt2), 32'h2);
      check_eq("wd_pulse_end", 32'(to2), 32'h0);
    end
`else
    check_eq("nowd_hold_gnt", 32'(gnt2), 32'h1);
    check_eq("nowd_timeout", 32'(to2), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("nowd_hold_gnt", 32'(gnt2), 32'h1);
      check_eq("nowd_timeout", 32'(to2), 32'h0);
    end
`endif
    // M0 lets go, then re-requests against an unlocked M1: round-robin hands it back to M0
    req2  = 2'b10;
    lock2 = 2'b00;
    tick();
    check_eq("wd_release_gnt", 32'(gnt2), 32'h2);
    req2 = 2'b11;
    tick();
    check_eq("wd_regrant_gnt", 32'(gnt2), 32'h1);
    req2 = 2'b00;
    tick();

    // Unlocked contention: round-robin rotates per beat, fixed priority sticks to M0
    req4r = 4'b1111;
    req4f = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("rr4_gnt", 32'(gnt4r), 32'h1 << (i % 4));
      check_eq("rr4_sel", 32'(sel4r), 32'(i % 4));
      check_eq("fx4_gnt", 32'(gnt4f), 32'h1);
    end
    req4f = 4'b1010;
    tick();
    check_eq("fx4_lowest_gnt", 32'(gnt4f), 32'h2);
    check_eq("fx4_lowest_sel", 32'(sel4f), 32'h1);
    req4f = 4'b0000;

    // Reset in the middle of a locked ownership of M2
    req4r  = 4'b0100;
    lock4r = 4'b0100;
    tick();
    check_eq("rr4_m2_gnt", 32'(gnt4r), 32'h4);
    req4r = 4'b1111;
    tick();
    check_eq("rr4_m2_lock_gnt", 32'(gnt4r), 32'h4);
    rst = 1'b1;
    tick();
    check_eq("midrst_gnt", 32'(gnt4r), 32'h0);
    check_eq("midrst_sel", 32'(sel4r), 32'h0);
    check_eq("midrst_busy", 32'(busy4r), 32'h0);
    check_eq("midrst_timeout", 32'(to4r), 32'h0);
    rst    = 1'b0;
    lock4r = 4'b0000;
    tick();
    check_eq("postrst_gnt", 32'(gnt4r), 32'h1);
    check_eq("postrst_sel", 32'(sel4r), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
